// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;
  localparam int REG_W    = 5;
  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    MD_WAIT
  } state_t;
endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags an ID source that needs the load result now in EX.
// Purely combinational, zero latency; r0 never creates a dependency.
module load_use_detect #(
  parameter int REG_W = hazard_pkg::REG_W
) (
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rn,
  input  logic [REG_W-1:0] ifid_rm,
  output logic             hit
);
  import hazard_pkg::*;

  assign hit = idex_memread && (idex_rd != REG_W'(REG_ZERO))
               && ((idex_rd == ifid_rn) || (idex_rd == ifid_rm));
endmodule

// File: rtl/hazard_sequencer.sv
// Hazard arbiter for the 5-stage core: memory wait > mul/div > branch flush > load-use.
// Outputs are combinational from registered state and current inputs (same-cycle effect).
module hazard_sequencer #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16,
  parameter int REG_W      = hazard_pkg::REG_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rn,
  input  logic [REG_W-1:0] ifid_rm,
  input  logic             ex_branch_taken,
  input  logic             idex_muldiv,
  input  logic             exmem_memreq,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_count
);
  import hazard_pkg::*;

  state_t     state, nextState;
  logic [3:0] mdCnt, nextMdCnt;
  logic       mdAck, nextMdAck;
  logic       loadUse, memStall, mdStart;

  load_use_detect #(.REG_W(REG_W)) uLoadUse (
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .ifid_rn      (ifid_rn),
    .ifid_rm      (ifid_rm),
    .hit          (loadUse)
  );

  assign memStall = exmem_memreq && !dmem_ready;
  assign mdStart  = idex_muldiv && !mdAck && (MULDIV_LAT > 1);

  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    exmem_we     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    muldiv_busy  = 1'b0;
    nextState    = state;
    nextMdCnt    = mdCnt;
    nextMdAck    = mdAck;

    case (state)
      MD_WAIT: begin
        muldiv_busy = 1'b1;
        if (memStall) begin
          // Memory freeze outranks the mul/div countdown, which holds its place.
          {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
          memwb_bubble = 1'b1;
        end else begin
          {pc_we, ifid_we, idex_we} = 3'b000;
          exmem_bubble = 1'b1;
          if (mdCnt == 4'd0) begin
            nextMdAck = 1'b1;
            nextState = RUN;
          end else begin
            nextMdCnt = mdCnt - 4'd1;
          end
        end
      end
      default: begin
        if ((state == MEM_WAIT) ? !dmem_ready : memStall) begin
          {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
          memwb_bubble = 1'b1;
          nextState    = MEM_WAIT;
          if (state == RUN) nextMdAck = 1'b0;
        end else begin
          nextState = RUN;
          if (mdStart) begin
            {pc_we, ifid_we, idex_we} = 3'b000;
            exmem_bubble = 1'b1;
            muldiv_busy  = 1'b1;
            if (MULDIV_LAT >= 3) begin
              nextMdCnt = 4'(MULDIV_LAT - 3);
              nextState = MD_WAIT;
            end else begin
              nextMdAck = 1'b1;
            end
          end else begin
            // Ack only needs to cover the cycle in which the finished op leaves EX.
            nextMdAck = 1'b0;
            if (ex_branch_taken) begin
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
            end else if (loadUse) begin
              pc_we      = 1'b0;
              ifid_we    = 1'b0;
              idex_flush = 1'b1;
            end
          end
        end
      end
    endcase

    if (!reset_n) begin
      {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_bubble = 1'b0;
      memwb_bubble = 1'b0;
      muldiv_busy  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      mdCnt       <= '0;
      mdAck       <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= nextState;
      mdCnt <= nextMdCnt;
      mdAck <= nextMdAck;
      if (!pc_we && (stall_count != {CNT_W{1'b1}})) stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule
